yuv422_to_yuv444: RTL and testbench
===================================

# yuv422_to_yuv444

Chroma upsampler that converts a packed 4:2:2 YCbCr pixel stream (one luma plus one alternating chroma sample per clock) into a 4:4:4 stream with separate Y, U (Cb) and V (Cr) channels per pixel. It sits directly upstream of the YUV-to-RGB converter and drives its `y_ch_i`/`u_ch_i`/`v_ch_i`/`vs_i`/`de_i` inputs. Chroma for odd pixels is either replicated or interpolated from the neighbouring pair. Timing is a fixed pipeline delay with no backpressure.

## Interface
- `INTERP`, default 0: 0 = odd pixel reuses its pair's chroma; 1 = odd pixel chroma averaged with the next pair's chroma.
- `CHROMA_ORDER`, default 0: 0 = first chroma sample of a line is Cb; 1 = first is Cr.
- `clk_i`  input  1  single clock; all logic on the rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `vs_i`  input  1  vertical sync; delayed only, no functional effect.
- `de_i`  input  1  data enable; high for valid pixels.
- `y_i`  input  8  luma sample.
- `c_i`  input  8  chroma sample, alternating Cb/Cr per `CHROMA_ORDER`.
- `vs_o`  output  1  `vs_i` delayed 4 clocks.
- `de_o`  output  1  `de_i` delayed 4 clocks.
- `y_ch_o`  output  8  luma.
- `u_ch_o`  output  8  Cb.
- `v_ch_o`  output  8  Cr.

## Operation
- **Line definition.** A line is a maximal run of consecutive cycles with `de_i` high. Any low cycle ends the line. The next rising `de_i` starts a new line at phase 0.
- **Phase toggle.** Phase toggles every valid pixel. Pixels 2k and 2k+1 form pair k.
  - With `CHROMA_ORDER`=0: `c_i` at phase 0 is Cb_k and at phase 1 is Cr_k.
  - With `CHROMA_ORDER`=1 the two are swapped.
- **Even pixel 2k** outputs Y_2k, Cb_k, Cr_k.
- **Odd pixel 2k+1**:
  - `INTERP`=0: outputs Y_2k+1, Cb_k, Cr_k.
  - `INTERP`=1: Cb = (Cb_k + Cb_k+1 + 1) >> 1 if pixel 2k+2 exists in the same line, else Cb_k.
  - `INTERP`=1: Cr = (Cr_k + Cr_k+1 + 1) >> 1 if pixel 2k+3 exists in the same line, else Cr_k.
  - Sums are 9-bit; the result is always ≤ 255 and never saturates.
- **Odd-length line.** The final even pixel 2k has no Cr_k of its own.
  - It uses Cr_k-1 from the same line if k > 0.
  - It uses 128 if the line is a single pixel.
- **Order handling.** Missing-sample substitution applies to whichever component (Cb or Cr) falls in phase 1.
- **Blanking.** When `de_o` is 0, `y_ch_o`, `u_ch_o` and `v_ch_o` are driven to 0.
- **No state carry.** No state survives between lines. Chroma from a previous line is never used.

## Timing
- **Latency.** Output pixel n appears exactly 4 clocks after input pixel n, for both `INTERP` values. `vs_o`/`de_o` use the same 4-clock delay.
- **Throughput.** One pixel per clock, continuous, with no stalls. Back-to-back lines separated by a single blanking cycle are supported.
- **Reset state.** While `rst_i` is high, and immediately on assertion (asynchronous), all outputs are 0. This covers `vs_o`, `de_o`, `y_ch_o`, `u_ch_o` and `v_ch_o`.
- **Reset clears:**
  - all pipeline stages,
  - the phase counter,
  - all held chroma.
- **Reset mid-line.** Pixels in flight are discarded, and no partial output is emitted after release. The first `de_i` high after deassertion starts at phase 0.
- **Interpolation lookahead.** The lookahead for odd pixel 2k+1 needs information at most up to input cycle 2k+3, or `de_i` falling earlier. The 4-clock latency covers this; the end-of-line decision uses the registered `de_i`.
- **Simultaneous events.** `vs_i` toggling while `de_i` is high has no effect on the data path.

## Test plan
- **Replicate mode.** `INTERP`=0, `CHROMA_ORDER`=0, line of (Y,C) = (16,100),(20,200),(24,110),(28,210).
  - Required output 4 clocks later: (16,100,200),(20,100,200),(24,110,210),(28,110,210).
  - `de_o` high for 4 cycles.
- **Interpolate mode.** Same stimulus with `INTERP`=1.
  - Required output: (16,100,200),(20,105,205),(24,110,210),(28,110,210).
- **Odd-length line.** `INTERP`=1, 3-pixel line (16,100),(20,200),(24,110).
  - Required output: (16,100,200),(20,105,200),(24,110,200).
  - Separately, a 1-pixel line (50,90) gives (50,90,128).
- **Chroma order and line restart.** `CHROMA_ORDER`=1, `INTERP`=0, line (30,60),(31,70), then 1 blanking cycle, then line (40,80),(41,90).
  - Required output: (30,70,60),(31,70,60), then 0s with `de_o`=0, then (40,90,80),(41,90,80).
  - Confirms phase restart and no chroma carry-over between lines.
- **Reset mid-line.** Assert `rst_i` for 1 cycle in the middle of a continuous 8-pixel line.
  - All outputs must read 0 in the same cycle as assertion, and `de_o` stays 0 for pixels captured before reset.
  - The following line must reproduce the first scenario exactly.
- **Sync alignment.** Randomized `vs_i`/`de_i` pattern over 2 frames.
  - `vs_o`/`de_o` must equal the inputs delayed 4 clocks.
  - Data must match the reference model, and blanking data must be 0.

Source files
------------

// File: rtl/yuv422_to_yuv444.sv
// 4:2:2 to 4:4:4 chroma upsampler: fixed 4-clock pipeline, chroma replicated or
// interpolated for odd pixels using up to two pixels of lookahead within a line.
module yuv422_to_yuv444 #(
    parameter int unsigned INTERP       = 0,
    parameter int unsigned CHROMA_ORDER = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       vs_i,
    input  logic       de_i,
    input  logic [7:0] y_i,
    input  logic [7:0] c_i,
    output logic       vs_o,
    output logic       de_o,
    output logic [7:0] y_ch_o,
    output logic [7:0] u_ch_o,
    output logic [7:0] v_ch_o
);

    localparam int unsigned DW    = 8;
    localparam int unsigned SW    = DW + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CUR   = 2;
    localparam logic [DW-1:0] C_MID = DW'(128);

    // Stage 0 is the newest sample; stage CUR is the pixel being emitted,
    // stages 0/1 are its lookahead and stage 3 its predecessor.
    logic               r_phase;
    logic [DEPTH-1:0]   r_de;
    logic [DEPTH-2:0]   r_vs;
    logic [DEPTH-2:0]   r_ph;
    logic [DW-1:0]      r_y [DEPTH-1];
    logic [DW-1:0]      r_c [DEPTH];

    logic [DW-1:0]      w_a;
    logic [DW-1:0]      w_b;
    logic [DW-1:0]      w_u;
    logic [DW-1:0]      w_v;

    function automatic logic [DW-1:0] avg_rnd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(1);
        return s[SW-1:1];
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase <= 1'b0;
            r_de    <= '0;
            r_vs    <= '0;
            r_ph    <= '0;
            for (int unsigned i = 0; i < DEPTH - 1; i++) r_y[i] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)     r_c[i] <= '0;
        end else begin
            // Phase restarts at 0 on every new line; any blanking cycle ends a line.
            r_phase <= de_i ? ~r_phase : 1'b0;
            r_de    <= {r_de[DEPTH-2:0], de_i};
            r_vs    <= {r_vs[DEPTH-3:0], vs_i};
            r_ph    <= {r_ph[DEPTH-3:0], r_phase};
            r_y[0]  <= y_i;
            r_c[0]  <= c_i;
            for (int unsigned i = 1; i < DEPTH - 1; i++) r_y[i] <= r_y[i-1];
            for (int unsigned i = 1; i < DEPTH; i++)     r_c[i] <= r_c[i-1];
        end
    end

    // w_a is the phase-0 chroma component, w_b the phase-1 component.
    always_comb begin
        w_a = r_c[CUR];
        w_b = r_c[CUR];
        if (!r_ph[CUR]) begin
            if (r_de[CUR-1]) begin
                w_b = r_c[CUR-1];
            end else if (r_de[CUR+1]) begin
                w_b = r_c[CUR+1];
            end else begin
                w_b = C_MID;
            end
        end else begin
            w_a = r_c[CUR+1];
            w_b = r_c[CUR];
            if (INTERP != 0) begin
                if (r_de[CUR-1]) begin
                    w_a = avg_rnd(r_c[CUR+1], r_c[CUR-1]);
                end
                if (r_de[CUR-1] && r_de[CUR-2]) begin
                    w_b = avg_rnd(r_c[CUR], r_c[CUR-2]);
                end
            end
        end
    end

    always_comb begin
        w_u = w_a;
        w_v = w_b;
        if (CHROMA_ORDER != 0) begin
            w_u = w_b;
            w_v = w_a;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_o   <= 1'b0;
            de_o   <= 1'b0;
            y_ch_o <= '0;
            u_ch_o <= '0;
            v_ch_o <= '0;
        end else begin
            vs_o <= r_vs[CUR];
            de_o <= r_de[CUR];
            if (r_de[CUR]) begin
                y_ch_o <= r_y[CUR];
                u_ch_o <= w_u;
                v_ch_o <= w_v;
            end else begin
                y_ch_o <= '0;
                u_ch_o <= '0;
                v_ch_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// Scoreboard bench: four INTERP/CHROMA_ORDER variants share one randomized stimulus
// stream; a line-level reference model predicts each output line.
module tb_yuv422_to_yuv444;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       vs_i;
    logic       de_i;
    logic [7:0] y_i;
    logic [7:0] c_i;

    logic       vs_o_a [4];
    logic       de_o_a [4];
    logic [7:0] y_a    [4];
    logic [7:0] u_a    [4];
    logic [7:0] v_a    [4];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  cur_y [$];
    logic [7:0]  cur_c [$];
    logic [23:0] exp_q [4][$];
    int          len_q [4][$];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cfg%0d t=%0t got %h expected %h", nm, g, $time, act, expv);
        end
    endtask

    // Reference: whole-line rules, applied once the line is known to have ended.
    task automatic push_line();
        int n, k, a, b, u, v;
        n = cur_y.size();
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < n; p++) begin
                k = p / 2;
                a = int'(cur_c[2*k]);
                if (2*k + 1 < n)  b = int'(cur_c[2*k+1]);
                else if (k > 0)   b = int'(cur_c[2*k-1]);
                else              b = 128;
                if ((p % 2 == 1) && (g % 2 == 1)) begin
                    if (2*k + 2 < n) a = (a + int'(cur_c[2*k+2]) + 1) / 2;
                    if (2*k + 3 < n) b = (b + int'(cur_c[2*k+3]) + 1) / 2;
                end
                u = (g / 2 == 1) ? b : a;
                v = (g / 2 == 1) ? a : b;
                exp_q[g].push_back({cur_y[p], 8'(u), 8'(v)});
            end
            len_q[g].push_back(n);
        end
        cur_y.delete();
        cur_c.delete();
    endtask

    task automatic drive(input logic vs, input logic de, input logic [7:0] y, input logic [7:0] c);
        @(posedge clk);
        #1;
        vs_i = vs;
        de_i = de;
        y_i  = y;
        c_i  = c;
        if (de) begin
            cur_y.push_back(y);
            cur_c.push_back(c);
        end else if (cur_y.size() > 0) begin
            push_line();
        end
    endtask

    task automatic px(input logic [7:0] y, input logic [7:0] c);
        drive(1'b0, 1'b1, y, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        vs_i  = 1'b0;
        de_i  = 1'b0;
        cur_y.delete();
        cur_c.delete();
        for (int g = 0; g < 4; g++) begin
            exp_q[g].delete();
            len_q[g].delete();
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic line_a();
        px(8'd16, 8'd100); px(8'd20, 8'd200); px(8'd24, 8'd110); px(8'd28, 8'd210);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        logic [23:0] cap [$];
        logic [1:0]  hist [4];

        yuv422_to_yuv444 #(.INTERP(g % 2), .CHROMA_ORDER(g / 2)) u_dut (
            .clk_i  (clk),
            .rst_i  (rst_i),
            .vs_i   (vs_i),
            .de_i   (de_i),
            .y_i    (y_i),
            .c_i    (c_i),
            .vs_o   (vs_o_a[g]),
            .de_o   (de_o_a[g]),
            .y_ch_o (y_a[g]),
            .u_ch_o (u_a[g]),
            .v_ch_o (v_a[g])
        );

        always @(negedge clk) begin
            int n;
            logic [23:0] e;
            if (rst_i) begin
                chk("rst_vs", g, 32'(vs_o_a[g]), 32'd0);
                chk("rst_de", g, 32'(de_o_a[g]), 32'd0);
                chk("rst_data", g, 32'({y_a[g], u_a[g], v_a[g]}), 32'd0);
                cap.delete();
                for (int i = 0; i < 4; i++) hist[i] = 2'b00;
            end else begin
                chk("vs_dly", g, 32'(vs_o_a[g]), 32'(hist[0][1]));
                chk("de_dly", g, 32'(de_o_a[g]), 32'(hist[0][0]));
                if (de_o_a[g]) begin
                    cap.push_back({y_a[g], u_a[g], v_a[g]});
                end else begin
                    chk("blank_data", g, 32'({y_a[g], u_a[g], v_a[g]}), 32'd0);
                    if (cap.size() > 0) begin
                        if (len_q[g].size() == 0) begin
                            chk("unexpected_line", g, 32'(cap.size()), 32'd0);
                        end else begin
                            n = len_q[g].pop_front();
                            chk("line_len", g, 32'(cap.size()), 32'(n));
                            for (int i = 0; i < n; i++) begin
                                e = exp_q[g].pop_front();
                                if (i < cap.size()) chk("pixel", g, 32'(cap[i]), 32'(e));
                            end
                        end
                        cap.delete();
                    end
                end
                for (int i = 0; i < 3; i++) hist[i] = hist[i+1];
                hist[3] = {vs_i, de_i};
            end
        end
    end

    initial begin
        int len;
        rst_i = 1'b1;
        vs_i  = 1'b0;
        de_i  = 1'b0;
        y_i   = 8'd0;
        c_i   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(2);

        line_a();
        idle(6);
        px(8'd16, 8'd100); px(8'd20, 8'd200); px(8'd24, 8'd110);
        idle(6);
        px(8'd50, 8'd90);
        idle(6);
        px(8'd30, 8'd60); px(8'd31, 8'd70);
        idle(1);
        px(8'd40, 8'd80); px(8'd41, 8'd90);
        idle(6);

        // Reset partway through an 8-pixel line, then the first line again.
        for (int i = 0; i < 5; i++) px(8'(60 + i), 8'(30 * i + 5));
        pulse_reset();
        idle(1);
        line_a();
        idle(6);

        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0, 8'd0);
            for (int l = 0; l < 7; l++) begin
                len = int'($urandom_range(1, 16));
                for (int p = 0; p < len; p++)
                    drive(($urandom % 8) == 0, 1'b1, 8'($urandom), 8'($urandom));
                for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                    drive(($urandom % 6) == 0, 1'b0, 8'($urandom), 8'($urandom));
            end
        end
        idle(10);

        for (int g = 0; g < 4; g++) begin
            chk("leftover_lines", g, 32'(len_q[g].size()), 32'd0);
            chk("leftover_pixels", g, 32'(exp_q[g].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
